mips_bus_master_arb: RTL and testbench

//  Parametrised Avalon-MM master shared by N_CH CPU-side requesters (fetch, load/store, debug).

---
 rtl/mips_bus_master_arb.sv | 255 +++++++++++++++++++++++++
 tb/tb_mips_bus_master_arb.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_master_arb.sv
// Round-robin Avalon-MM master shared by N_CH CPU-side requesters.
// Optional waitrequest timeout: define MIPS_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mips_bus_master_arb #(
   parameter int N_CH           = 2,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        req_valid,
   output logic [N_CH-1:0]        req_ready,
   input  logic [N_CH-1:0]        req_write,
   input  logic [N_CH-1:0]        req_signed,
   input  logic [2*N_CH-1:0]      req_size,
   input  logic [ADDR_W*N_CH-1:0] req_addr,
   input  logic [32*N_CH-1:0]     req_wdata,
   output logic [N_CH-1:0]        rsp_valid,
   output logic                   rsp_err,
   output logic [31:0]            rsp_rdata,
   output logic [ADDR_W-1:0]      address,
   output logic                   read,
   output logic                   write,
   input  logic                   waitrequest,
   output logic [31:0]            writedata,
   output logic [3:0]             byteenable,
   input  logic [31:0]            readdata
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]     ptr;
   logic [CW-1:0]     gnt_q;
   logic [CW-1:0]     gnt_idx;
   logic              gnt_found;
   logic [CW:0]       rr;

   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [1:0]        sel_size;
   logic              sel_write;
   logic              sel_signed;
   logic              sel_err;
   logic [3:0]        sel_be;
   logic [31:0]       sel_lanes;
   logic [1:0]        k_sel;
   logic [4:0]        sh;

   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              signed_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;

   logic [4:0]        lo;
   logic [4:0]        ho;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_val;

   logic              accept;
   logic              bus_done;
   logic              timeout_hit;

   // Round-robin search: first valid channel at or after the pointer
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      rr        = '0;
      for (int i = 0; i < N_CH; i++) begin
         rr = {1'b0, ptr} + (CW+1)'(i);
         if (rr >= (CW+1)'(N_CH))
            rr = rr - (CW+1)'(N_CH);
         if (!gnt_found && req_valid[rr[CW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = rr[CW-1:0];
         end
      end
   end

   assign sel_addr   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_wdata  = req_wdata[gnt_idx*32 +: 32];
   assign sel_size   = req_size[gnt_idx*2 +: 2];
   assign sel_write  = req_write[gnt_idx];
   assign sel_signed = req_signed[gnt_idx];

   // Alignment check, byte enables and big-endian lane placement of store data
   always_comb begin
      k_sel     = sel_addr[1:0];
      sh        = {k_sel, 3'b000};
      sel_err   = 1'b0;
      sel_be    = 4'b0000;
      sel_lanes = 32'h0;
      case (sel_size)
         2'b00: begin
            sel_be    = 4'b0001 << k_sel;
            sel_lanes = {24'h0, sel_wdata[7:0]} << sh;
         end
         2'b01: begin
            sel_err   = k_sel[0];
            sel_be    = k_sel[1] ? 4'b1100 : 4'b0011;
            sel_lanes = {16'h0, sel_wdata[7:0],
                         sel_wdata[15:8]} << sh;
         end
         2'b10: begin
            sel_err   = |k_sel;
            sel_be    = 4'b1111;
            sel_lanes = {sel_wdata[7:0], sel_wdata[15:8],
                         sel_wdata[23:16], sel_wdata[31:24]};
         end
         default: sel_err = 1'b1;
      endcase
   end

   // Reassemble load data from lanes and extend to 32 bits
   always_comb begin
      lo       = {addr_q[1:0], 3'b000};
      ho       = {addr_q[1], 4'b0000};
      lane_b   = readdata[lo +: 8];
      lane_h   = {readdata[ho +: 8], readdata[ho + 5'd8 +: 8]};
      load_val = 32'h0;
      case (size_q)
         2'b00:
            load_val = signed_q ? {{24{lane_b[7]}}, lane_b}
                                : {24'h0, lane_b};
         2'b01:
            load_val = signed_q ? {{16{lane_h[15]}}, lane_h}
                                : {16'h0, lane_h};
         default:
            load_val = {readdata[7:0], readdata[15:8],
                        readdata[23:16], readdata[31:24]};
      endcase
   end

`ifdef MIPS_BUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;

   // Count stalled bus cycles; cleared whenever no bus cycle is active
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         to_cnt <= '0;
      else if (state != BUS)
         to_cnt <= '0;
      else if (waitrequest)
         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout_hit = (state == BUS) && waitrequest &&
                        (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Bus cycles wait forever; the timeout length has no effect here
   assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state, handshake strobes and bus outputs
   always_comb begin
      state_nx   = state;
      req_ready  = '0;
      rsp_valid  = '0;
      accept     = 1'b0;
      bus_done   = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      writedata  = 32'h0;
      byteenable = 4'b0000;
      rsp_err    = 1'b0;
      rsp_rdata  = 32'h0;
      case (state)
         IDLE: begin
            if (gnt_found) begin
               accept             = 1'b1;
               req_ready[gnt_idx] = reset;
               state_nx           = sel_err ? RESP : BUS;
            end
         end
         BUS: begin
            read       = !write_q;
            write      = write_q;
            address    = {addr_q[ADDR_W-1:2], 2'b00};
            writedata  = wdata_q;
            byteenable = be_q;
            if (!waitrequest) begin
               bus_done = 1'b1;
               state_nx = RESP;
            end else if (timeout_hit) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_err          = err_q;
            rsp_rdata        = rdata_q;
            state_nx         = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Capture the granted request, advance the pointer, latch load data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         gnt_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         be_q     <= 4'b0000;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
      end else begin
         if (accept) begin
            gnt_q    <= gnt_idx;
            ptr      <= (gnt_idx == CW'(N_CH - 1)) ? '0
                                                   : gnt_idx + 1'b1;
            addr_q   <= sel_addr;
            write_q  <= sel_write;
            signed_q <= sel_signed;
            err_q    <= sel_err;
            size_q   <= sel_size;
            be_q     <= sel_be;
            wdata_q  <= sel_write ? sel_lanes : 32'h0;
            rdata_q  <= 32'h0;
         end
         if (bus_done && !write_q)
            rdata_q <= load_val;
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_bus_master_arb.sv
// Bench for mips_bus_master_arb: vector table, directed corner
// sequences and a random run against a transaction-level model.
`timescale 1ns/1ps
module tb_mips_bus_master_arb;

   localparam int N  = 3;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_write;
   logic [N-1:0]    req_signed;
   logic [2*N-1:0]  req_size;
   logic [AW*N-1:0] req_addr;
   logic [32*N-1:0] req_wdata;
   logic [N-1:0]    rsp_valid;
   logic            rsp_err;
   logic [31:0]     rsp_rdata;
   logic [AW-1:0]   address;
   logic            read;
   logic            write;
   logic            waitrequest;
   logic [31:0]     writedata;
   logic [3:0]      byteenable;
   logic [31:0]     readdata;

   int errors = 0;
   int checks = 0;

   mips_bus_master_arb #(
      .N_CH(N), .ADDR_W(AW), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_signed(req_signed),
      .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .address(address), .read(read), .write(write),
      .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      int          ch;
      logic        wr;
      logic        sg;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          waits;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_rdata;
      logic        e_err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input int ch, input logic wr, input logic sg,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      req_valid[ch]        = 1'b1;
      req_write[ch]        = wr;
      req_signed[ch]       = sg;
      req_size[2*ch +: 2]  = sz;
      req_addr[AW*ch +: AW] = a;
      req_wdata[32*ch +: 32] = wd;
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      req_valid   = '0;
      waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Reference model helpers, from the byte-lane rules
   function automatic logic m_err(input logic [1:0] sz, input int k);
      int n;
      n = 1 << sz;
      return (sz == 2'd3) || ((k % n) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz,
                                       input int k);
      int n;
      logic [3:0] be;
      n  = 1 << sz;
      be = 4'b0000;
      for (int j = 0; j < n; j++) be[k+j] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_lanes(input logic [1:0] sz,
                                           input int k,
                                           input logic [31:0] wd);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = 32'h0;
      for (int j = 0; j < n; j++)
         v[8*(k+j) +: 8] = wd[8*(n-1-j) +: 8];
      return v;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz,
                                          input int k, input logic sg,
                                          input logic [31:0] rd);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = 32'h0;
      for (int j = 0; j < n; j++)
         v = (v << 8) | 32'(rd[8*(k+j) +: 8]);
      if (sg && n < 4 && v[8*n-1])
         v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int  cyc;
      int  hold;
      bit  done;
      string t;
      t = $sformatf("v%0d", idx);
      set_req(v.ch, v.wr, v.sg, v.sz, v.addr, v.wd);
      waitrequest = (v.waits > 0) && !v.e_err;
      readdata    = v.rd;
      @(negedge clk);
      check({t, " ready"}, 32'(req_ready), 32'(1 << v.ch));
      @(posedge clk);
      #1 req_valid = '0;
      if (!v.e_err) begin
         cyc  = 0;
         hold = 0;
         done = 0;
         while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (read || write) hold++;
            check({t, " read"}, 32'(read), 32'(!v.wr));
            check({t, " write"}, 32'(write), 32'(v.wr));
            check({t, " address"}, address, v.e_addr);
            check({t, " be"}, 32'(byteenable), 32'(v.e_be));
            check({t, " writedata"}, writedata, v.e_wd);
            check({t, " rsp_valid busy"}, 32'(rsp_valid), 0);
            if (!waitrequest) begin
               done = 1;
            end else begin
               @(posedge clk);
               #1 waitrequest = (cyc < v.waits);
            end
         end
         check({t, " strobe cycles"}, hold, v.waits + 1);
         @(posedge clk);
         #1;
         @(negedge clk);
      end else begin
         @(negedge clk);
         check({t, " no strobe"}, 32'({read, write}), 0);
      end
      check({t, " rsp_valid"}, 32'(rsp_valid), 32'(1 << v.ch));
      check({t, " rsp_err"}, 32'(rsp_err), 32'(v.e_err));
      check({t, " rsp_rdata"}, rsp_rdata, v.e_rdata);
      @(posedge clk);
      #1;
   endtask

   // Random run state
   logic        m_pend[N];
   logic        m_wr[N];
   logic        m_sg[N];
   logic [1:0]  m_sz[N];
   logic [31:0] m_ad[N];
   logic [31:0] m_wd[N];

   initial begin
      int n;
      int ng;
      int g;
      int ptr;
      int mph;
      int cch;
      int k;
      int wrun;
      int r;
      bit done;
      logic        c_wr;
      logic        c_sg;
      logic        c_err;
      logic [1:0]  c_sz;
      logic [31:0] c_ad;
      logic [31:0] c_lanes;
      logic [31:0] c_rdata;
      logic [3:0]  c_be;
      logic [N-1:0] exp_rdy;
      string t;

      // ch wr sg sz addr wd rd waits | e_addr be e_wd e_rdata e_err
      vecs[0]  = '{0, 0, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h7856_3412, 0,
                   32'hBFC0_0000, 4'b1111, 32'h0, 32'h1234_5678, 0};
      vecs[1]  = '{1, 0, 1, 2'b00, 32'h0000_1003, 32'h0, 32'h8000_0000, 0,
                   32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 0};
      vecs[2]  = '{1, 0, 0, 2'b00, 32'h0000_1003, 32'h0, 32'h8000_0000, 0,
                   32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 0};
      vecs[3]  = '{0, 1, 0, 2'b01, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3,
                   32'h0000_2000, 4'b1100, 32'hCDAB_0000, 32'h0, 0};
      vecs[4]  = '{0, 0, 0, 2'b10, 32'h0000_1002, 32'h0, 32'hFFFF_FFFF, 0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1};
      vecs[5]  = '{2, 1, 0, 2'b00, 32'h0000_3001, 32'h1234_56EF, 32'h0, 1,
                   32'h0000_3000, 4'b0010, 32'h0000_EF00, 32'h0, 0};
      vecs[6]  = '{2, 1, 0, 2'b10, 32'h0000_4000, 32'h1122_3344, 32'h0, 0,
                   32'h0000_4000, 4'b1111, 32'h4433_2211, 32'h0, 0};
      vecs[7]  = '{0, 0, 1, 2'b01, 32'h0000_5002, 32'h0, 32'h80F0_1234, 2,
                   32'h0000_5000, 4'b1100, 32'h0, 32'hFFFF_F080, 0};
      vecs[8]  = '{1, 0, 0, 2'b01, 32'h0000_5002, 32'h0, 32'h80F0_1234, 0,
                   32'h0000_5000, 4'b1100, 32'h0, 32'h0000_F080, 0};
      vecs[9]  = '{2, 0, 0, 2'b11, 32'h0000_6000, 32'h0, 32'h1111_1111, 0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1};
      vecs[10] = '{1, 1, 0, 2'b01, 32'h0000_6001, 32'h0000_BEEF, 32'h0, 0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1};
      vecs[11] = '{0, 0, 1, 2'b00, 32'h0000_7001, 32'h0, 32'h0000_7F00, 0,
                   32'h0000_7000, 4'b0010, 32'h0, 32'h0000_007F, 0};

      reset       = 1'b0;
      req_valid   = '0;
      req_write   = '0;
      req_signed  = '0;
      req_size    = '0;
      req_addr    = '0;
      req_wdata   = '0;
      waitrequest = 1'b0;
      readdata    = 32'h0;

      // Reset state, with a request pending to prove it is ignored
      set_req(0, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset req_ready", 32'(req_ready), 0);
      check("reset strobes", 32'({read, write}), 0);
      check("reset rsp", 32'({rsp_valid, rsp_err}), 0);
      check("reset rsp_rdata", rsp_rdata, 0);
      check("reset address", address, 0);
      check("reset be/wd", {byteenable, writedata[27:0]}, 0);
      req_valid = '0;
      @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Async reset in the middle of a stalled read
      set_req(2, 1'b0, 1'b0, 2'b10, 32'h8000, 32'h0);
      waitrequest = 1'b1;
      @(negedge clk);
      check("rstbus ready", 32'(req_ready), 32'b100);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("rstbus read before", 32'(read), 1);
      #2 reset = 1'b0;
      #1;
      check("rstbus read dropped", 32'({read, write}), 0);
      check("rstbus address", address, 0);
      @(posedge clk);
      #1 begin
         reset       = 1'b1;
         waitrequest = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rstbus quiet%0d", i),
               32'({rsp_valid, read, write}), 0);
      end
      @(posedge clk);
      #1;

      // Two channels held valid: grants alternate from channel 0
      set_req(0, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b10, 32'h200, 32'h0);
      readdata = 32'hA5A5_5A5A;
      ng = 0;
      n  = 0;
      while (ng < 4 && n < 40) begin
         @(negedge clk);
         n++;
         if (req_ready != '0) begin
            check($sformatf("rr grant%0d", ng), 32'(req_ready),
                  32'(1 << (ng % 2)));
            ng++;
         end
         if (ng < 4) begin
            @(posedge clk);
            #1;
         end
      end
      check("rr grant count", ng, 4);
      @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // Waitrequest stuck high
      set_req(0, 1'b0, 1'b0, 2'b10, 32'h9000, 32'h0);
      waitrequest = 1'b1;
      @(negedge clk);
      check("to ready", 32'(req_ready), 32'b001);
      @(posedge clk);
      #1 req_valid = '0;
`ifdef MIPS_BUS_TIMEOUT_EN
      n    = 0;
      done = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         if (read) n++;
         else done = 1;
      end
      check("to read cycles", n, 4);
      check("to rsp_valid", 32'(rsp_valid), 32'b001);
      check("to rsp_err", 32'(rsp_err), 1);
      check("to rsp_rdata", rsp_rdata, 0);
      @(posedge clk);
      #1 waitrequest = 1'b0;
`else
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (read) n++;
         check($sformatf("stall%0d rsp", i), 32'(rsp_valid), 0);
      end
      check("stall read cycles", n, 20);
      @(posedge clk);
      #1 waitrequest = 1'b0;
      @(negedge clk);
      check("stall final read", 32'(read), 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("stall rsp_valid", 32'(rsp_valid), 32'b001);
      check("stall rsp_err", 32'(rsp_err), 0);
      @(posedge clk);
      #1;
`endif

      // Random traffic against the transaction model
      do_reset();
      for (int c = 0; c < N; c++) m_pend[c] = 1'b0;
      ptr     = 0;
      mph     = 0;
      cch     = 0;
      wrun    = 0;
      c_wr    = 1'b0;
      c_sg    = 1'b0;
      c_err   = 1'b0;
      c_sz    = 2'b00;
      c_ad    = 32'h0;
      c_lanes = 32'h0;
      c_rdata = 32'h0;
      c_be    = 4'b0000;
      k       = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         t       = $sformatf("rnd%0d", cyc);
         g       = -1;
         exp_rdy = '0;
         if (mph == 0)
            for (int i = 0; i < N; i++)
               if (g < 0 && m_pend[(ptr + i) % N]) g = (ptr + i) % N;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check({t, " ready"}, 32'(req_ready), 32'(exp_rdy));
         if (mph == 1) begin
            check({t, " rw"}, 32'({read, write}), 32'({!c_wr, c_wr}));
            check({t, " address"}, address, {c_ad[31:2], 2'b00});
            check({t, " be"}, 32'(byteenable), 32'(c_be));
            check({t, " writedata"}, writedata, c_lanes);
         end else begin
            check({t, " rw idle"}, 32'({read, write}), 0);
         end
         if (mph == 2) begin
            check({t, " rsp_valid"}, 32'(rsp_valid), 32'(1 << cch));
            check({t, " rsp_err"}, 32'(rsp_err), 32'(c_err));
            check({t, " rsp_rdata"}, rsp_rdata, c_rdata);
         end else begin
            check({t, " rsp_valid idle"}, 32'(rsp_valid), 0);
         end
         case (mph)
            0: if (g >= 0) begin
               cch       = g;
               c_wr      = m_wr[g];
               c_sg      = m_sg[g];
               c_sz      = m_sz[g];
               c_ad      = m_ad[g];
               k         = int'(c_ad[1:0]);
               c_err     = m_err(c_sz, k);
               c_be      = c_err ? 4'b0000 : m_be(c_sz, k);
               c_lanes   = (c_err || !c_wr) ? 32'h0
                                            : m_lanes(c_sz, k, m_wd[g]);
               c_rdata   = 32'h0;
               m_pend[g] = 1'b0;
               ptr       = (g + 1) % N;
               mph       = c_err ? 2 : 1;
            end
            1: if (!waitrequest) begin
               if (!c_wr) c_rdata = m_load(c_sz, k, c_sg, readdata);
               mph = 2;
            end
            default: mph = 0;
         endcase
         @(posedge clk);
         #1;
         for (int c = 0; c < N; c++) begin
            if (!m_pend[c]) begin
               req_valid[c] = 1'b0;
               if ($urandom % 4 == 0) begin
                  r       = int'($urandom % 8);
                  m_sz[c] = (r == 7) ? 2'd3 : 2'(r % 3);
                  m_wr[c] = 1'($urandom);
                  m_sg[c] = 1'($urandom);
                  m_ad[c] = $urandom;
                  m_wd[c] = $urandom;
                  if ($urandom % 2 == 0) begin
                     if (m_sz[c] == 2'd1) m_ad[c][0] = 1'b0;
                     if (m_sz[c] == 2'd2) m_ad[c][1:0] = 2'b00;
                  end
                  m_pend[c] = 1'b1;
                  set_req(c, m_wr[c], m_sg[c], m_sz[c], m_ad[c], m_wd[c]);
               end
            end
         end
         if (wrun >= 2) waitrequest = 1'b0;
         else waitrequest = ($urandom % 3 == 0);
         wrun     = waitrequest ? wrun + 1 : 0;
         readdata = $urandom;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
